// File: rtl/frame_draw_ctrl_if.sv
// Bus bundle for the per-frame sequencer: frame request/status, the
// crosshair drawer handshake and pass-through, and the VGA write port.
// The slave view belongs to the sequencer; the master view is its environment.
interface frame_draw_ctrl_if;

    // Frame request and status
    logic        frame_start;
    logic [7:0]  center_x;
    logic [6:0]  center_y;
    logic        busy;
    logic        frame_done;

    // Crosshair drawer control
    logic        xh_start;
    logic [7:0]  xh_center_x;
    logic [6:0]  xh_center_y;
    logic        xh_done;

    // Crosshair drawer VGA signals, forwarded while it owns the frame
    logic [7:0]  xh_x;
    logic [6:0]  xh_y;
    logic [17:0] xh_colour;
    logic        xh_write;

    // VGA adapter write port
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;

    modport slave (
        input  frame_start,
        input  center_x,
        input  center_y,
        output busy,
        output frame_done,
        output xh_start,
        output xh_center_x,
        output xh_center_y,
        input  xh_done,
        input  xh_x,
        input  xh_y,
        input  xh_colour,
        input  xh_write,
        output vga_x,
        output vga_y,
        output vga_colour,
        output vga_write
    );

    modport master (
        output frame_start,
        output center_x,
        output center_y,
        input  busy,
        input  frame_done,
        input  xh_start,
        input  xh_center_x,
        input  xh_center_y,
        output xh_done,
        output xh_x,
        output xh_y,
        output xh_colour,
        output xh_write,
        input  vga_x,
        input  vga_y,
        input  vga_colour,
        input  vga_write
    );

endinterface

// File: rtl/frame_draw_ctrl.sv
// Per-frame sequencer in front of the crosshair drawer. Each accepted
// request clears the whole screen to the background colour in raster order,
// one pixel per cycle, then hands the VGA port to the crosshair drawer until
// it reports done, and finally pulses frame_done. This block is the only
// driver of the VGA write port for the duration of a frame.
module frame_draw_ctrl #(
    parameter int          SCREEN_W  = 160,
    parameter int          SCREEN_H  = 120,
    parameter logic [17:0] BG_COLOUR = 18'b0
) (
    input  logic             clock,
    input  logic             resetn,
    frame_draw_ctrl_if.slave bus
);

    // Last valid coordinates; the counters are sized for a 256x128 screen at most
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        XH_START,
        XH_WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  cx;
    logic [7:0]  cx_next;
    logic [6:0]  cy;
    logic [6:0]  cy_next;

    logic [7:0]  lat_x;
    logic [7:0]  lat_x_next;
    logic [6:0]  lat_y;
    logic [6:0]  lat_y_next;

    logic        busy;
    logic        frame_done;
    logic        xh_start;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [17:0] vga_colour;
    logic        vga_write;

    // State, clear-pass raster counters and latched crosshair centre
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
            lat_x <= '0;
            lat_y <= '0;
        end else begin
            state <= state_next;
            cx    <= cx_next;
            cy    <= cy_next;
            lat_x <= lat_x_next;
            lat_y <= lat_y_next;
        end
    end

    // Next-state, counter advance and output decode for every state
    always_comb begin
        state_next = state;
        cx_next    = cx;
        cy_next    = cy;
        lat_x_next = lat_x;
        lat_y_next = lat_y;
        busy       = 1'b1;
        frame_done = 1'b0;
        xh_start   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = BG_COLOUR;
        vga_write  = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.frame_start) begin
                    lat_x_next = bus.center_x;
                    lat_y_next = bus.center_y;
                    cx_next    = '0;
                    cy_next    = '0;
                    state_next = CLEAR;
                end
            end

            CLEAR: begin
                vga_write  = 1'b1;
                vga_x      = cx;
                vga_y      = cy;
                vga_colour = BG_COLOUR;
                if (cx < X_LAST) begin
                    cx_next = cx + 8'd1;
                end else if (cy < Y_LAST) begin
                    cx_next = '0;
                    cy_next = cy + 7'd1;
                end else begin
                    cx_next    = '0;
                    cy_next    = '0;
                    state_next = XH_START;
                end
            end

            XH_START: begin
                xh_start   = 1'b1;
                state_next = XH_WAIT;
            end

            XH_WAIT: begin
                vga_x      = bus.xh_x;
                vga_y      = bus.xh_y;
                vga_colour = bus.xh_colour;
                vga_write  = bus.xh_write;
                if (bus.xh_done) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end

            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy        = busy;
    assign bus.frame_done  = frame_done;
    assign bus.xh_start    = xh_start;
    assign bus.xh_center_x = lat_x;
    assign bus.xh_center_y = lat_y;
    assign bus.vga_x       = vga_x;
    assign bus.vga_y       = vga_y;
    assign bus.vga_colour  = vga_colour;
    assign bus.vga_write   = vga_write;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Directed bench for frame_draw_ctrl with a small behavioural crosshair
// drawer attached. Inputs change and outputs are sampled on the falling edge.
module tb_frame_draw_ctrl;

    localparam logic [17:0] XH_COL = 18'b000111000111000111;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;
    int step     = 0;

    logic xh_done_force  = 1'b0;
    logic xh_write_force = 1'b0;

    frame_draw_ctrl_if bus ();

    frame_draw_ctrl dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    // 100 MHz-style free-running clock
    always #5 clock = ~clock;

    // Crosshair drawer sequencing: five pixel writes, then one done cycle
    always @(posedge clock) begin
        if (!resetn)
            step <= 0;
        else if (step == 0)
            step <= bus.xh_start ? 1 : 0;
        else if (step < 6)
            step <= step + 1;
        else
            step <= 0;
    end

    // Crosshair drawer VGA outputs derived from its step and the latched centre
    always_comb begin
        bus.xh_write  = xh_write_force || (step >= 1 && step <= 5);
        bus.xh_done   = xh_done_force || (step == 6);
        bus.xh_colour = (step >= 1 && step <= 5) ? XH_COL : 18'b0;
        bus.xh_x      = 8'd0;
        bus.xh_y      = 7'd0;
        case (step)
            1: begin bus.xh_x = bus.xh_center_x;        bus.xh_y = bus.xh_center_y;        end
            2: begin bus.xh_x = bus.xh_center_x;        bus.xh_y = bus.xh_center_y - 7'd1; end
            3: begin bus.xh_x = bus.xh_center_x + 8'd1; bus.xh_y = bus.xh_center_y;        end
            4: begin bus.xh_x = bus.xh_center_x;        bus.xh_y = bus.xh_center_y + 7'd1; end
            5: begin bus.xh_x = bus.xh_center_x - 8'd1; bus.xh_y = bus.xh_center_y;        end
            default: ;
        endcase
    end

    // Count every frame_done pulse seen at a rising edge
    always @(posedge clock) begin
        if (bus.frame_done)
            fd_count <= fd_count + 1;
    end

    task automatic nextCycle();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic fs, input logic [7:0] cx, input logic [6:0] cy);
        bus.frame_start = fs;
        bus.center_x    = cx;
        bus.center_y    = cy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first CLEAR cycle; returns in the first IDLE cycle after DONE
    task automatic checkFrame(input logic [7:0] ex, input logic [6:0] ey,
                              input logic keep, input logic glitch);
        int bad;
        int fd0;
        logic [7:0] px;
        logic [6:0] py;
        bad = 0;
        fd0 = fd_count;
        for (int i = 0; i < 19200; i++) begin
            if (bus.vga_write !== 1'b1 || bus.vga_x !== 8'(i % 160) ||
                bus.vga_y !== 7'(i / 160) || bus.vga_colour !== 18'b0 ||
                bus.busy !== 1'b1 || bus.xh_start !== 1'b0 || bus.frame_done !== 1'b0)
                bad++;
            if (glitch && i == 499) applyStimulus(1'b1, 8'd100, 7'd100);
            if (glitch && i == 500) applyStimulus(keep, 8'd100, 7'd100);
            if (glitch && i == 700) xh_done_force = 1'b1;
            if (glitch && i == 701) xh_done_force = 1'b0;
            nextCycle();
        end
        checkOutput("clear_bad_pixels", 32'(bad), 32'd0);

        checkOutput("xh_start_pulse", 32'(bus.xh_start), 32'd1);
        checkOutput("xh_start_vga_write", 32'(bus.vga_write), 32'd0);
        checkOutput("xh_center_x", 32'(bus.xh_center_x), 32'(ex));
        checkOutput("xh_center_y", 32'(bus.xh_center_y), 32'(ey));
        nextCycle();

        for (int k = 0; k < 5; k++) begin
            px = ex;
            py = ey;
            case (k)
                1: py = ey - 7'd1;
                2: px = ex + 8'd1;
                3: py = ey + 7'd1;
                4: px = ex - 8'd1;
                default: ;
            endcase
            checkOutput("xh_write", 32'(bus.vga_write), 32'd1);
            checkOutput("xh_pixel_x", 32'(bus.vga_x), 32'(px));
            checkOutput("xh_pixel_y", 32'(bus.vga_y), 32'(py));
            checkOutput("xh_colour", 32'(bus.vga_colour), 32'(XH_COL));
            if (glitch && k == 3) applyStimulus(1'b1, 8'd100, 7'd100);
            if (glitch && k == 4) applyStimulus(keep, 8'd100, 7'd100);
            nextCycle();
        end

        checkOutput("xh_done_cycle_write", 32'(bus.vga_write), 32'd0);
        checkOutput("xh_done_cycle_frame_done", 32'(bus.frame_done), 32'd0);
        nextCycle();

        checkOutput("frame_done_pulse", 32'(bus.frame_done), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd1);
        checkOutput("done_vga_write", 32'(bus.vga_write), 32'd0);
        nextCycle();

        checkOutput("idle_frame_done", 32'(bus.frame_done), 32'd0);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("frame_done_count", 32'(fd_count - fd0), 32'd1);
    endtask

    // Linear directed test sequence
    initial begin
        applyStimulus(1'b0, 8'd0, 7'd0);
        resetn = 1'b0;

        // Reset held for three cycles, then released with no request
        repeat (3) nextCycle();
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_vga_write", 32'(bus.vga_write), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            checkOutput("idle_busy_after_reset", 32'(bus.busy), 32'd0);
            checkOutput("idle_write_after_reset", 32'(bus.vga_write), 32'd0);
            checkOutput("idle_xh_start_after_reset", 32'(bus.xh_start), 32'd0);
            checkOutput("idle_frame_done_after_reset", 32'(bus.frame_done), 32'd0);
        end
        checkOutput("reset_center_x", 32'(bus.xh_center_x), 32'd0);
        checkOutput("reset_center_y", 32'(bus.xh_center_y), 32'd0);
        checkOutput("idle_vga_x", 32'(bus.vga_x), 32'd0);
        checkOutput("idle_vga_colour", 32'(bus.vga_colour), 32'd0);

        // Full frame centred at (80,60)
        $display("[TB] full frame at (80,60)");
        applyStimulus(1'b1, 8'd80, 7'd60);
        nextCycle();
        applyStimulus(1'b0, 8'd80, 7'd60);
        checkFrame(8'd80, 7'd60, 1'b0, 1'b0);

        // Centre latching, ignored restarts and stray drawer signals
        $display("[TB] latched centre (10,20) with mid-frame disturbances");
        applyStimulus(1'b1, 8'd10, 7'd20);
        nextCycle();
        applyStimulus(1'b0, 8'd10, 7'd20);
        checkFrame(8'd10, 7'd20, 1'b0, 1'b1);
        checkOutput("idle_center_held_x", 32'(bus.xh_center_x), 32'd10);
        checkOutput("idle_center_held_y", 32'(bus.xh_center_y), 32'd20);
        xh_write_force = 1'b1;
        xh_done_force  = 1'b1;
        checkOutput("stray_xh_write_blocked", 32'(bus.vga_write), 32'd0);
        nextCycle();
        xh_write_force = 1'b0;
        xh_done_force  = 1'b0;
        checkOutput("stray_xh_done_ignored", 32'(bus.busy), 32'd0);
        checkOutput("stray_xh_done_no_frame_done", 32'(bus.frame_done), 32'd0);

        // Reset in CLEAR cycle 1000 aborts the frame
        $display("[TB] mid-frame reset");
        applyStimulus(1'b1, 8'd5, 7'd5);
        nextCycle();
        applyStimulus(1'b0, 8'd5, 7'd5);
        repeat (999) nextCycle();
        checkOutput("clear_1000_x", 32'(bus.vga_x), 32'd39);
        checkOutput("clear_1000_y", 32'(bus.vga_y), 32'd6);
        resetn = 1'b0;
        nextCycle();
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_vga_write", 32'(bus.vga_write), 32'd0);
        checkOutput("abort_center_x", 32'(bus.xh_center_x), 32'd0);
        checkOutput("abort_frame_done", 32'(bus.frame_done), 32'd0);
        resetn = 1'b1;

        // Restart with frame_start held high for back-to-back frames
        $display("[TB] restart and back-to-back frames at (30,40)");
        applyStimulus(1'b1, 8'd30, 7'd40);
        nextCycle();
        checkOutput("restart_x", 32'(bus.vga_x), 32'd0);
        checkOutput("restart_y", 32'(bus.vga_y), 32'd0);
        checkFrame(8'd30, 7'd40, 1'b1, 1'b0);
        nextCycle();
        checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
        checkOutput("b2b_write", 32'(bus.vga_write), 32'd1);
        checkOutput("b2b_x", 32'(bus.vga_x), 32'd0);
        checkOutput("b2b_y", 32'(bus.vga_y), 32'd0);
        nextCycle();
        checkOutput("b2b_x_next", 32'(bus.vga_x), 32'd1);
        applyStimulus(1'b0, 8'd0, 7'd0);
        resetn = 1'b0;
        nextCycle();
        resetn = 1'b1;
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_draw_ctrl.md
Name: frame_draw_ctrl

Overview:
- Per-frame sequencer directly upstream of the crosshair drawer.
- On each frame request it clears the 160x120 VGA buffer to a background colour, one pixel per cycle.
- It then issues a start pulse to the crosshair drawer, forwards the drawer's VGA signals to the adapter, waits for the drawer's done, and reports frame completion.
- It is the single owner of the VGA write port during a frame.

Parameters:
- SCREEN_W, 160, pixels per row; x counter wraps at SCREEN_W-1.
- SCREEN_H, 120, rows per frame; y counter terminates at SCREEN_H-1.
- BG_COLOUR, 18'b0, colour written during the clear pass.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- frame_start  in  1  request to draw one frame; sampled only in IDLE.
- center_x  in  8  crosshair centre x in pixels; latched on an accepted frame_start.
- center_y  in  7  crosshair centre y in pixels; latched on an accepted frame_start.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- xh_start  out  1  one-cycle start pulse to the crosshair drawer.
- xh_center_x  out  8  latched centre x, held stable for the whole frame.
- xh_center_y  out  7  latched centre y, held stable for the whole frame.
- xh_done  in  1  crosshair drawer completion.
- xh_x  in  8  crosshair drawer VGA x.
- xh_y  in  7  crosshair drawer VGA y.
- xh_colour  in  18  crosshair drawer VGA colour.
- xh_write  in  1  crosshair drawer VGA write strobe.
- vga_x  out  8  pixel x to the VGA adapter.
- vga_y  out  7  pixel y to the VGA adapter.
- vga_colour  out  18  pixel colour to the VGA adapter.
- vga_write  out  1  write strobe to the VGA adapter.

Behaviour:
- Reset (resetn low at a clock edge):
  - state=IDLE; cx=0, cy=0; latched centre=0.
  - busy, frame_done, xh_start and vga_write are 0.
  - resetn low mid-frame aborts the frame immediately, with no frame_done.
- States and transitions:
  - IDLE: when frame_start=1, latch center_x/center_y and go to CLEAR with cx=0, cy=0.
  - CLEAR: each cycle, vga_write=1, vga_x=cx, vga_y=cy, vga_colour=BG_COLOUR. Then:
    - if cx<SCREEN_W-1: cx++.
    - else if cy<SCREEN_H-1: cx=0, cy++.
    - else (last pixel SCREEN_W-1, SCREEN_H-1): cx=0, cy=0, go to XH_START.
    - Raster order with x as the inner loop; exactly SCREEN_W*SCREEN_H (19200) write cycles; no pixel is skipped or repeated.
  - XH_START: xh_start=1 for exactly this one cycle; vga_write=0; go to XH_WAIT.
  - XH_WAIT: vga_x/vga_y/vga_colour/vga_write are combinationally driven from xh_x/xh_y/xh_colour/xh_write. On xh_done=1, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, vga_write=0, busy=1; go to IDLE.
- Outputs outside CLEAR and XH_WAIT: vga_x=0, vga_y=0, vga_colour=BG_COLOUR, vga_write=0.
- xh_center_x/xh_center_y always reflect the latched registers, not the live inputs.
- frame_start is ignored while busy; centre changes mid-frame have no effect.
- If frame_start is held high continuously, a new frame begins on the cycle after DONE, i.e. the first cycle in IDLE.
- xh_done arriving in any state other than XH_WAIT is ignored.
- xh_write asserted outside XH_WAIT never reaches vga_write.
- Latency: an accepted frame_start in IDLE at cycle 0 gives CLEAR in cycles 1..19200 and xh_start in cycle 19201. frame_done follows the xh_done cycle by exactly 1.
- Widths: cx is 8 bits and cy 7 bits; SCREEN_W<=256 and SCREEN_H<=128 are required. No arithmetic overflow is possible within range.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release with frame_start=0 -> busy=0, vga_write=0, xh_start=0, frame_done=0 indefinitely.
- Full frame: frame_start pulse with centre (80,60), paired with the real crosshair drawer -> 19200 BG writes covering (0,0)..(159,119) once each in raster order, then xh_start in cycle 19201. Then 5 writes of 18'b000111000111000111 at (80,60), (80,59), (81,60), (80,61), (79,60), then one frame_done pulse.
- Centre latching: frame_start with centre (10,20), then change the inputs to (100,100) during CLEAR -> xh_center stays (10,20) and crosshair writes are centred at (10,20).
- Ignored start: pulse frame_start at cycles 500 and 19205 of a frame -> no restart, and exactly one frame_done.
- Mid-frame reset: resetn=0 at CLEAR cycle 1000 -> the next cycle is IDLE with vga_write=0. A new frame_start then restarts the clear at (0,0).
- Back-to-back: frame_start held at 1 throughout -> a second CLEAR pass begins at (0,0) on the cycle after the first frame_done, with no gap beyond the IDLE acceptance cycle.
